// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data-memory responder.
interface dmem_responder_if;
   logic        EX_MEM_MemRead;
   logic        EX_MEM_MemWrite;
   logic [2:0]  EX_MEM_funct3;
   logic [31:0] EX_MEM_ALUResult;
   logic [31:0] EX_MEM_RData2;
   logic [31:0] RData;
   logic        Mem_Stall;

   modport master (
      output EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_funct3, EX_MEM_ALUResult, EX_MEM_RData2,
      input  RData, Mem_Stall
   );

   modport slave (
      input  EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_funct3, EX_MEM_ALUResult, EX_MEM_RData2,
      output RData, Mem_Stall
   );
endinterface

// File: rtl/dmem_responder.sv
// RV32 data-memory responder: byte/half/word loads and stores on a little-endian word array,
// with word-straddling accesses split over two cycles.
module dmem_responder #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW = ADDR_W + 2;

   typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              store_q, store_d;
   logic [31:0]       low_q, low_d;

   logic [31:0]       mem [DEPTH];

   logic [AW-1:0]     a_addr;
   logic [2:0]        a_f3;
   logic [31:0]       a_wdata;
   logic              a_store;
   logic              a_valid;
   logic [ADDR_W-1:0] idx0, idx1;
   logic [4:0]        sh;
   logic [7:0]        en8;
   logic [63:0]       wd64;
   logic              split;
   logic [31:0]       word0, word1;

   logic [31:0]       rdata_c;
   logic              stall_c;
   logic              we_c;
   logic [ADDR_W-1:0] wr_idx_c;
   logic [3:0]        wr_be_c;
   logic [31:0]       wr_data_c;
   logic              unused_addr_hi;

   function automatic logic load_legal(input logic [2:0] f3);
      return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic logic store_legal(input logic [2:0] f3);
      return f3 inside {3'b000, 3'b001, 3'b010};
   endfunction

   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b100:  return {24'h0, raw[7:0]};
         3'b101:  return {16'h0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   assign unused_addr_hi = ^bus.EX_MEM_ALUResult[31:AW];

   // In SECOND the captured request replaces the live bus entirely.
   always_comb begin
      if (state_q == SECOND) begin
         a_addr  = addr_q;
         a_f3    = funct3_q;
         a_wdata = wdata_q;
         a_store = store_q;
         a_valid = 1'b1;
      end else begin
         a_addr  = bus.EX_MEM_ALUResult[AW-1:0];
         a_f3    = bus.EX_MEM_funct3;
         a_wdata = bus.EX_MEM_RData2;
         a_store = bus.EX_MEM_MemWrite;
         a_valid = bus.EX_MEM_MemWrite ? store_legal(bus.EX_MEM_funct3)
                                       : (bus.EX_MEM_MemRead && load_legal(bus.EX_MEM_funct3));
      end
   end

   // Byte lanes over a two-word window; the upper nibble belongs to word N+1.
   assign idx0  = a_addr[AW-1:2];
   assign idx1  = idx0 + ADDR_W'(1);
   assign sh    = {a_addr[1:0], 3'b000};
   assign en8   = {4'b0000, size_mask(a_f3[1:0])} << a_addr[1:0];
   assign wd64  = {32'h0, a_wdata} << sh;
   assign split = |en8[7:4];
   assign word0 = mem[idx0];
   assign word1 = mem[idx1];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      funct3_d  = funct3_q;
      wdata_d   = wdata_q;
      store_d   = store_q;
      low_d     = low_q;
      rdata_c   = 32'h0;
      stall_c   = 1'b0;
      we_c      = 1'b0;
      wr_idx_c  = idx0;
      wr_be_c   = 4'b0000;
      wr_data_c = wd64[31:0];

      case (state_q)
         IDLE: begin
            if (a_valid && !rst) begin
               if (split) begin
                  stall_c  = 1'b1;
                  state_d  = SECOND;
                  addr_d   = a_addr;
                  funct3_d = a_f3;
                  wdata_d  = a_wdata;
                  store_d  = a_store;
                  if (a_store) begin
                     we_c    = 1'b1;
                     wr_be_c = en8[3:0];
                  end else begin
                     low_d = word0 & byte_mask(en8[3:0]);
                  end
               end else if (a_store) begin
                  we_c    = 1'b1;
                  wr_be_c = en8[3:0];
               end else begin
                  rdata_c = extend(a_f3, word0 >> sh);
               end
            end
         end
         SECOND: begin
            state_d = IDLE;
            if (!rst) begin
               if (a_store) begin
                  we_c      = 1'b1;
                  wr_idx_c  = idx1;
                  wr_be_c   = en8[7:4];
                  wr_data_c = wd64[63:32];
               end else begin
                  rdata_c = extend(a_f3, 32'({word1, low_q} >> sh));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.RData     = rdata_c;
   assign bus.Mem_Stall = stall_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         funct3_q <= 3'b000;
         wdata_q  <= 32'h0;
         store_q  <= 1'b0;
         low_q    <= 32'h0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         wdata_q  <= wdata_d;
         store_q  <= store_d;
         low_q    <= low_d;
      end
   end

   // Byte-enabled write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be_c[b]) mem[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan cases plus a random sweep against a byte-array model.
module tb_dmem_responder;
   localparam int unsigned DEPTH = 256;
   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

   typedef struct {
      logic        r, rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, d, x;
      logic        s;
      string       name;
   } op_t;

   typedef struct {
      logic [31:0] rdata;
      logic        stall;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [7:0] ref_mem [4*DEPTH];
   logic [2:0] lds [5];
   logic [2:0] sts [3];

   dmem_responder_if ifc ();

   dmem_responder #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   function automatic op_t mk(input logic r, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] x,
                              input logic s, input string n);
      op_t o;
      o.r = r; o.rd = rd; o.wr = wr; o.f3 = f3; o.a = a; o.d = d; o.x = x; o.s = s; o.name = n;
      return o;
   endfunction

   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic is_split(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a[1:0]) + nbytes(f3)) > 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < nbytes(f3); i++) v[8*i +: 8] = ref_mem[(a + 32'(i)) & (4*DEPTH - 1)];
      case (f3)
         F_B:     return {{24{v[7]}}, v[7:0]};
         F_H:     return {{16{v[15]}}, v[15:0]};
         default: return v;
      endcase
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < nbytes(f3); i++) ref_mem[(a + 32'(i)) & (4*DEPTH - 1)] = d[8*i +: 8];
   endtask

   // Drive one cycle of inputs at the falling edge and sample the combinational outputs.
   task automatic step(input logic r, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] o_rd, output logic o_st);
      @(negedge clk);
      rst                  = r;
      ifc.EX_MEM_MemRead   = rd;
      ifc.EX_MEM_MemWrite  = wr;
      ifc.EX_MEM_funct3    = f3;
      ifc.EX_MEM_ALUResult = a;
      ifc.EX_MEM_RData2    = d;
      #2;
      o_rd = ifc.RData;
      o_st = ifc.Mem_Stall;
   endtask

   task automatic test_reset;
      op_t ops[$]; exp_t e; logic [31:0] ord; logic ost;
      ops.push_back(mk(1, 1, 0, F_W, 32'h10, 32'h0, 32'h0, 0, "rst_lw"));
      ops.push_back(mk(1, 0, 1, F_W, 32'h22, 32'hFFFF_FFFF, 32'h0, 0, "rst_split_sw"));
      ops.push_back(mk(1, 1, 0, F_W, 32'h22, 32'h0, 32'h0, 0, "rst_split_lw"));
      ops.push_back(mk(0, 0, 1, F_W, 32'h40, 32'h1111_1111, 32'h0, 0, "sw40"));
      ops.push_back(mk(1, 0, 1, F_W, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, "rst_sw40"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h40, 32'h0, 32'h1111_1111, 0, "lw40_after_rst"));
      ops.push_back(mk(0, 0, 0, F_W, 32'h40, 32'h0, 32'h0, 0, "no_request"));
      for (int i = 0; i < ops.size(); i++) begin
         sb.push_back('{ops[i].x, ops[i].s, ops[i].name});
         step(ops[i].r, ops[i].rd, ops[i].wr, ops[i].f3, ops[i].a, ops[i].d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
   endtask

   task automatic test_aligned;
      op_t ops[$]; exp_t e; logic [31:0] ord; logic ost;
      ops.push_back(mk(0, 0, 1, F_W,  32'h10, 32'h8765_4321, 32'h0, 0, "sw10"));
      ops.push_back(mk(0, 1, 0, F_W,  32'h10, 32'h0, 32'h8765_4321, 0, "lw10"));
      ops.push_back(mk(0, 1, 0, F_B,  32'h13, 32'h0, 32'hFFFF_FF87, 0, "lb13"));
      ops.push_back(mk(0, 1, 0, F_BU, 32'h13, 32'h0, 32'h0000_0087, 0, "lbu13"));
      ops.push_back(mk(0, 1, 0, F_H,  32'h12, 32'h0, 32'hFFFF_8765, 0, "lh12"));
      ops.push_back(mk(0, 1, 0, F_HU, 32'h10, 32'h0, 32'h0000_4321, 0, "lhu10"));
      ops.push_back(mk(0, 1, 0, F_B,  32'h10, 32'h0, 32'h0000_0021, 0, "lb10"));
      ops.push_back(mk(0, 1, 0, F_H,  32'h11, 32'h0, 32'h0000_6543, 0, "lh11"));
      ops.push_back(mk(0, 0, 1, F_W,  32'h10, 32'h0, 32'h0, 0, "sw10_zero"));
      ops.push_back(mk(0, 0, 1, F_B,  32'h11, 32'h1234_56AA, 32'h0, 0, "sb11"));
      ops.push_back(mk(0, 1, 0, F_W,  32'h10, 32'h0, 32'h0000_AA00, 0, "lw10_after_sb"));
      ops.push_back(mk(0, 0, 1, F_H,  32'h12, 32'h9876_BEEF, 32'h0, 0, "sh12"));
      ops.push_back(mk(0, 1, 0, F_W,  32'h10, 32'h0, 32'hBEEF_AA00, 0, "lw10_after_sh"));
      ops.push_back(mk(0, 1, 1, F_W,  32'h10, 32'h0102_0304, 32'h0, 0, "rd_wr_is_store"));
      ops.push_back(mk(0, 1, 0, F_W,  32'h10, 32'h0, 32'h0102_0304, 0, "lw10_after_rdwr"));
      for (int i = 0; i < ops.size(); i++) begin
         sb.push_back('{ops[i].x, ops[i].s, ops[i].name});
         step(ops[i].r, ops[i].rd, ops[i].wr, ops[i].f3, ops[i].a, ops[i].d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
   endtask

   task automatic test_split_load;
      op_t ops[$]; exp_t e; logic [31:0] ord; logic ost;
      ops.push_back(mk(0, 0, 1, F_W, 32'h20, 32'h4433_2211, 32'h0, 0, "sw20"));
      ops.push_back(mk(0, 0, 1, F_W, 32'h24, 32'h8877_6655, 32'h0, 0, "sw24"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h22, 32'h0, 32'h0, 1, "lw22_first"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h00, 32'h0, 32'h6655_4433, 0, "lw22_second_live_addr0"));
      ops.push_back(mk(0, 1, 0, F_H, 32'h23, 32'h0, 32'h0, 1, "lh23_first"));
      ops.push_back(mk(0, 0, 1, F_W, 32'h24, 32'hFFFF_FFFF, 32'h0000_5544, 0, "lh23_second_live_store"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h21, 32'h0, 32'h0, 1, "lw21_first"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h21, 32'h0, 32'h5544_3322, 0, "lw21_second"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h24, 32'h0, 32'h8877_6655, 0, "lw24_untouched"));
      for (int i = 0; i < ops.size(); i++) begin
         sb.push_back('{ops[i].x, ops[i].s, ops[i].name});
         step(ops[i].r, ops[i].rd, ops[i].wr, ops[i].f3, ops[i].a, ops[i].d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
   endtask

   task automatic test_wrap;
      op_t ops[$]; exp_t e; logic [31:0] ord; logic ost;
      logic [31:0] last;
      last = 32'(4*DEPTH - 1);
      ops.push_back(mk(0, 0, 1, F_W, last - 32'd3, 32'h5566_7788, 32'h0, 0, "sw_lastword"));
      ops.push_back(mk(0, 0, 1, F_W, 32'h0, 32'h1122_3344, 32'h0, 0, "sw_word0"));
      ops.push_back(mk(0, 0, 1, F_W, last, 32'hDDCC_BBAA, 32'h0, 1, "sw_wrap_first"));
      ops.push_back(mk(0, 0, 1, F_W, last, 32'hDDCC_BBAA, 32'h0, 0, "sw_wrap_second"));
      ops.push_back(mk(0, 1, 0, F_W, last - 32'd3, 32'h0, 32'hAA66_7788, 0, "lw_lastword"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h0, 32'h0, 32'h11DD_CCBB, 0, "lw_word0"));
      ops.push_back(mk(0, 1, 0, F_W, last, 32'h0, 32'h0, 1, "lw_wrap_first"));
      ops.push_back(mk(0, 1, 0, F_W, last, 32'h0, 32'hDDCC_BBAA, 0, "lw_wrap_second"));
      for (int i = 0; i < ops.size(); i++) begin
         sb.push_back('{ops[i].x, ops[i].s, ops[i].name});
         step(ops[i].r, ops[i].rd, ops[i].wr, ops[i].f3, ops[i].a, ops[i].d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
   endtask

   task automatic test_rst_second;
      op_t ops[$]; exp_t e; logic [31:0] ord; logic ost;
      ops.push_back(mk(0, 0, 1, F_W, 32'h30, 32'h0, 32'h0, 0, "sw30_zero"));
      ops.push_back(mk(0, 0, 1, F_W, 32'h34, 32'h1234_5678, 32'h0, 0, "sw34"));
      ops.push_back(mk(0, 0, 1, F_W, 32'h31, 32'hDDCC_BBAA, 32'h0, 1, "sw31_first"));
      ops.push_back(mk(1, 0, 1, F_W, 32'h31, 32'hDDCC_BBAA, 32'h0, 0, "sw31_rst_in_second"));
      ops.push_back(mk(0, 0, 0, F_W, 32'h31, 32'h0, 32'h0, 0, "idle_after_rst"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h30, 32'h0, 32'hCCBB_AA00, 0, "lw30_low_part"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h34, 32'h0, 32'h1234_5678, 0, "lw34_unchanged"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h31, 32'h0, 32'h0, 1, "lw31_first_from_idle"));
      ops.push_back(mk(0, 1, 0, F_W, 32'h31, 32'h0, 32'h78CC_BBAA, 0, "lw31_second"));
      for (int i = 0; i < ops.size(); i++) begin
         sb.push_back('{ops[i].x, ops[i].s, ops[i].name});
         step(ops[i].r, ops[i].rd, ops[i].wr, ops[i].f3, ops[i].a, ops[i].d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
   endtask

   task automatic test_illegal;
      op_t ops[$]; exp_t e; logic [31:0] ord; logic ost;
      ops.push_back(mk(0, 0, 1, F_W,    32'h50, 32'h5A5A_5A5A, 32'h0, 0, "sw50"));
      ops.push_back(mk(0, 0, 1, 3'b011, 32'h50, 32'hFFFF_FFFF, 32'h0, 0, "st_f3_011"));
      ops.push_back(mk(0, 0, 1, 3'b011, 32'h51, 32'hFFFF_FFFF, 32'h0, 0, "st_f3_011_unaligned"));
      ops.push_back(mk(0, 0, 1, F_BU,   32'h50, 32'hFFFF_FFFF, 32'h0, 0, "st_f3_100"));
      ops.push_back(mk(0, 0, 1, 3'b110, 32'h52, 32'hFFFF_FFFF, 32'h0, 0, "st_f3_110"));
      ops.push_back(mk(0, 1, 0, 3'b111, 32'h50, 32'h0, 32'h0, 0, "ld_f3_111"));
      ops.push_back(mk(0, 1, 0, 3'b011, 32'h51, 32'h0, 32'h0, 0, "ld_f3_011_unaligned"));
      ops.push_back(mk(0, 1, 0, F_W,    32'h50, 32'h0, 32'h5A5A_5A5A, 0, "lw50_unchanged"));
      for (int i = 0; i < ops.size(); i++) begin
         sb.push_back('{ops[i].x, ops[i].s, ops[i].name});
         step(ops[i].r, ops[i].rd, ops[i].wr, ops[i].f3, ops[i].a, ops[i].d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
   endtask

   task automatic test_random;
      exp_t e; logic [31:0] ord; logic ost;
      logic [31:0] a, d; logic [2:0] f3; logic wr, sp; int cyc;
      for (int w = 0; w < 64; w++) begin
         a = 32'h100 + 32'(4*w);
         d = $urandom;
         model_store(F_W, a, d);
         sb.push_back('{32'h0, 1'b0, "rand_fill"});
         step(0, 0, 1, F_W, a, d, ord, ost);
         e = sb.pop_front();
         total++;
         if (ord !== e.rdata || ost !== e.stall) begin
            bad++;
            $display("FAIL %s: got rdata=%h stall=%b, want rdata=%h stall=%b", e.name, ord, ost, e.rdata, e.stall);
         end
      end
      for (int n = 0; n < 120; n++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = wr ? sts[$urandom_range(0, 2)] : lds[$urandom_range(0, 4)];
         a  = 32'h100 + 32'($urandom_range(0, 247));
         d  = $urandom;
         sp = is_split(f3, a);
         if (wr) begin
            sb.push_back('{32'h0, sp, "rand_store"});
            if (sp) sb.push_back('{32'h0, 1'b0, "rand_store_second"});
            model_store(f3, a, d);
         end else begin
            if (sp) sb.push_back('{32'h0, 1'b1, "rand_load_first"});
            sb.push_back('{model_load(f3, a), 1'b0, "rand_load"});
         end
         cyc = sp ? 2 : 1;
         for (int c = 0; c < cyc; c++) begin
            step(0, ~wr, wr, f3, a, d, ord, ost);
            e = sb.pop_front();
            total++;
            if (ord !== e.rdata || ost !== e.stall) begin
               bad++;
               $display("FAIL %s: f3=%b addr=%h got rdata=%h stall=%b, want rdata=%h stall=%b",
                        e.name, f3, a, ord, ost, e.rdata, e.stall);
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      ifc.EX_MEM_MemRead   = 1'b0;
      ifc.EX_MEM_MemWrite  = 1'b0;
      ifc.EX_MEM_funct3    = 3'b000;
      ifc.EX_MEM_ALUResult = 32'h0;
      ifc.EX_MEM_RData2    = 32'h0;
      lds[0] = F_B; lds[1] = F_H; lds[2] = F_W; lds[3] = F_BU; lds[4] = F_HU;
      sts[0] = F_B; sts[1] = F_H; sts[2] = F_W;
      repeat (2) @(posedge clk);
      test_reset();
      test_aligned();
      test_split_load();
      test_wrap();
      test_rst_second();
      test_illegal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
